sa_job_arbiter: RTL
===================

SA_JOB_ARBITER -- requirements
Module: sa_job_arbiter

Interface
REQ-001 Parameter N, default 4: matrix dimension of the shared systolic array, with int8 elements.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum BUSY cycles allowed before the job is aborted.
REQ-003 i_clk  input  1  sole clock; all state on the rising edge.
REQ-004 i_arst  input  1  reset, synchronous, active-high.
REQ-005 i_reqValid  input  [1:0]  per-requester job request.
REQ-006 o_reqReady  output  [1:0]  per-requester job accept; one-hot or zero.
REQ-007 i_reqA, i_reqB  input  [1:0][N-1:0][N-1:0][7:0] signed  per-requester operand matrices.
REQ-008 o_rspValid  output  [1:0]  per-requester result valid; one-hot or zero.
REQ-009 i_rspReady  input  [1:0]  per-requester result accept.
REQ-010 o_rspC  output  [N-1:0][N-1:0][7:0] signed  result matrix, shared by both requesters.
REQ-011 o_rspErr  output  1  qualifies o_rspValid; 1 = job timed out.
REQ-012 o_saA, o_saB  output  [N-1:0][N-1:0][7:0] signed  operands to the array.
REQ-013 o_saValidInput  output  1  single-cycle job start pulse to the array.
REQ-014 i_saC  input  [N-1:0][N-1:0][7:0] signed  array result.
REQ-015 i_saValidResult  input  1  array result strobe.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, BUSY and RESP, and SHALL hold at most one job in flight.
REQ-017 In IDLE, when any i_reqValid bit is high, the block SHALL combinationally assert o_reqReady for the granted requester only.
REQ-018 On that cycle's edge it SHALL capture the granted i_reqA/i_reqB and move to LAUNCH.
REQ-019 Grant SHALL be round-robin: with both requesters valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-020 The last-grant pointer SHALL update only when a job is accepted.
REQ-021 In LAUNCH, o_saValidInput SHALL be 1 for exactly one cycle, then the FSM SHALL move to BUSY.
REQ-022 o_saA/o_saB SHALL hold the captured operands from acceptance until the next acceptance.
REQ-023 In BUSY, i_saValidResult=1 SHALL capture i_saC into o_rspC, clear o_rspErr and move to RESP; o_rspValid rises on the next cycle.
REQ-024 The BUSY counter SHALL start at 0 on BUSY entry; on reaching TIMEOUT_CYCLES-1 without a result, the FSM SHALL move to RESP with o_rspC=0 and o_rspErr=1.
REQ-025 If a result and a timeout occur in the same cycle, the result SHALL win.
REQ-026 In RESP, o_rspValid[grant] SHALL stay high with o_rspC/o_rspErr stable until i_rspReady[grant]=1, then the FSM SHALL return to IDLE.
REQ-027 i_rspReady of the non-granted requester SHALL be ignored.
REQ-028 i_saValidResult outside BUSY SHALL be ignored.
REQ-029 o_reqReady SHALL be 0 in every state except IDLE.
REQ-030 A new job SHALL NOT be accepted in the same cycle a response completes.
REQ-031 Minimum accept-to-response latency SHALL be 2 cycles plus the array latency (3N-1 cycles).

Reset
REQ-032 On i_arst, the FSM SHALL go to IDLE, the grant pointer SHALL be cleared, and all outputs SHALL be 0 on the following cycle.
REQ-033 Reset mid-job SHALL drop the job without a response.

Configuration
REQ-034 With SA_ARB_TIMEOUT_EN defined, the timeout of REQ-024 SHALL be active.
REQ-035 Without SA_ARB_TIMEOUT_EN, there SHALL be no counter, BUSY SHALL wait indefinitely, and o_rspErr SHALL be tied to 0.

Structure
REQ-036 Package sa_pkg SHALL hold the FSM state enum, the default N, the default TIMEOUT_CYCLES and the int8 element typedef.
REQ-037 Round-robin grant logic SHALL be a sub-module, sa_rr_arb2 (inputs: 2 requests, last-grant pointer; output: one-hot grant).

Verification
REQ-038 Single job: request 0, A=identity, B all 3, array model returns C → rspValid=2'b01 with C=B and rspErr=0; o_saValidInput pulses exactly once.
REQ-039 Contention: both requesters held valid for 4 jobs → grants alternate 0,1,0,1; o_reqReady never 2'b11.
REQ-040 Backpressure: i_rspReady held low for 10 cycles → o_rspValid and o_rspC held stable and no new job is accepted.
REQ-041 Timeout (macro on): no i_saValidResult → rspValid at BUSY entry + 64 cycles with rspErr=1 and C=0; a result strobe in the same cycle wins with err=0.
REQ-042 Reset mid-BUSY: i_arst for 1 cycle → all outputs 0 and no response; the next job is granted to requester 0.
REQ-043 Spurious i_saValidResult in IDLE or RESP → no state change and o_rspC unchanged.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array job arbiter.
package sa_pkg;

  localparam int SA_N_DEFAULT       = 4;
  localparam int SA_TIMEOUT_DEFAULT = 64;

  typedef logic signed [7:0] sa_int8_t;

  typedef enum logic [1:0] {
    SA_IDLE   = 2'd0,
    SA_LAUNCH = 2'd1,
    SA_BUSY   = 2'd2,
    SA_RESP   = 2'd3
  } sa_state_e;

endpackage

// File: rtl/sa_rr_arb2.sv
// Two-way round-robin grant; an all-zero last-grant pointer favours requester 0.
module sa_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic [1:0] i_lastGrant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        if (i_lastGrant[0])      o_grant = 2'b10;
        else if (i_lastGrant[1]) o_grant = 2'b01;
        else                     o_grant = 2'b01;
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sa_job_arbiter.sv
// Shares one systolic array between two requesters, one job in flight at a time.
// Build option: define SA_ARB_TIMEOUT_EN to abort BUSY jobs after TIMEOUT_CYCLES.
//
//   state     | meaning
//   SA_IDLE   | waiting for a request; grant offered combinationally
//   SA_LAUNCH | one-cycle start pulse to the array
//   SA_BUSY   | waiting for the array result (or timeout)
//   SA_RESP   | result held for the granted requester until accepted
module sa_job_arbiter
  import sa_pkg::*;
#(
  parameter int N              = SA_N_DEFAULT,
  parameter int TIMEOUT_CYCLES = SA_TIMEOUT_DEFAULT
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst,
  input  logic [1:0]                           i_reqValid,
  output logic [1:0]                           o_reqReady,
  input  logic signed [1:0][N-1:0][N-1:0][7:0] i_reqA,
  input  logic signed [1:0][N-1:0][N-1:0][7:0] i_reqB,
  output logic [1:0]                           o_rspValid,
  input  logic [1:0]                           i_rspReady,
  output logic signed [N-1:0][N-1:0][7:0]      o_rspC,
  output logic                                 o_rspErr,
  output logic signed [N-1:0][N-1:0][7:0]      o_saA,
  output logic signed [N-1:0][N-1:0][7:0]      o_saB,
  output logic                                 o_saValidInput,
  input  logic signed [N-1:0][N-1:0][7:0]      i_saC,
  input  logic                                 i_saValidResult
);

  typedef logic signed [N-1:0][N-1:0][7:0] mat_t;

  sa_state_e  state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q,  last_d;
  mat_t       a_q, a_d;
  mat_t       b_q, b_d;
  mat_t       c_q, c_d;
  logic [1:0] arb_grant;
  logic       timeout;

  sa_rr_arb2 u_rr (
    .i_req       (i_reqValid),
    .i_lastGrant (last_q),
    .o_grant     (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      SA_IDLE: begin
        if (arb_grant != 2'b00) begin
          grant_d = arb_grant;
          last_d  = arb_grant;
          a_d     = i_reqA[arb_grant[1]];
          b_d     = i_reqB[arb_grant[1]];
          state_d = SA_LAUNCH;
        end
      end
      SA_LAUNCH: state_d = SA_BUSY;
      SA_BUSY: begin
        // A result arriving on the timeout cycle takes precedence.
        if (i_saValidResult) begin
          c_d     = i_saC;
          state_d = SA_RESP;
        end else if (timeout) begin
          c_d     = '0;
          state_d = SA_RESP;
        end
      end
      SA_RESP: begin
        if ((i_rspReady & grant_q) != 2'b00) state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= SA_IDLE;
      grant_q <= 2'b00;
      last_q  <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

`ifdef SA_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout = (state_q == SA_BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_arst || state_q != SA_BUSY) cnt_q <= '0;
    else                              cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      err_q <= 1'b0;
    end else if (state_q == SA_BUSY) begin
      if (i_saValidResult) err_q <= 1'b0;
      else if (timeout)    err_q <= 1'b1;
    end
  end

  assign o_rspErr = err_q;
`else
  logic unused_timeout_param;

  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout              = 1'b0;
  assign o_rspErr             = 1'b0;
`endif

  assign o_reqReady     = (state_q == SA_IDLE && !i_arst) ? arb_grant : 2'b00;
  assign o_rspValid     = (state_q == SA_RESP) ? grant_q : 2'b00;
  assign o_saValidInput = (state_q == SA_LAUNCH);
  assign o_saA          = a_q;
  assign o_saB          = b_q;
  assign o_rspC         = c_q;

endmodule
